// File: rtl/serializer_pkg.sv
// Shared types and sizing for the result byte serializer.
// Defaults match the 32-bit p**4 result path.
package serializer_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int BYTE_W_DEF = 8;
    localparam int NBYTES     = DATA_W_DEF / BYTE_W_DEF;

    // A single-byte word still needs a one-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = idx_width(NBYTES);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/byte_index_counter.sv
// Byte position counter for the serializer.
// Clear wins over enable; tc flags the last byte of a word.
module byte_index_counter #(
    parameter int NBYTES = 4,
    parameter int IDX_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] idx,
    output logic             tc
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

    // Index register: clear on word load, step on each non-final byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (en) begin
            idx <= idx + 1'b1;
        end
    end

    // Terminal count decoded from the registered index.
    assign tc = (idx == LAST);

endmodule

// File: rtl/result_byte_serializer.sv
// Splits 32-bit power-unit results into a byte stream.
// One-word holding register; overflowing words are counted.
module result_byte_serializer
    import serializer_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BYTE_W    = BYTE_W_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_valid,
    output logic              data_in_ready,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_out_valid,
    input  logic              byte_out_ready,
    output logic              busy,
    output logic [7:0]        drop_cnt
);

    localparam int NB   = DATA_W / BYTE_W;
    localparam int IW   = idx_width(NB);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] hold_q;
    logic              hold_full_q;
    logic [IW-1:0]     idx;
    logic              last;
    logic              accept;
    logic              drop;
    logic              xfer;
    logic              in_send;
    logic              word_end;
    logic              idx_clr;
    logic              idx_en;
    logic [DATA_W-1:0] sh_shifted;

    assign in_send  = (state_q == SEND);
    assign accept   = data_in_valid && data_in_ready;
    assign drop     = data_in_valid && !data_in_ready;
    assign xfer     = byte_out_valid && byte_out_ready;
    assign word_end = in_send && xfer && last;
    assign idx_clr  = (!in_send && accept) || word_end;
    assign idx_en   = in_send && xfer && !last;

    byte_index_counter #(
        .NBYTES (NB),
        .IDX_W  (IW)
    ) u_idx (
        .clk (clk),
        .rst (rst),
        .clr (idx_clr),
        .en  (idx_en),
        .idx (idx),
        .tc  (last)
    );

    // Emitting end of the shifter and the shift toward it.
    generate
        if (MSB_FIRST) begin : g_msb
            assign byte_out   = sh_q[DATA_W-1 -: BYTE_W];
            assign sh_shifted = sh_q << BYTE_W;
        end else begin : g_lsb
            assign byte_out   = sh_q[BYTE_W-1:0];
            assign sh_shifted = sh_q >> BYTE_W;
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave SEND only when the last byte goes with nothing queued.
    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            !in_send: begin
                if (accept) state_d = SEND;
            end
            in_send: begin
                if (word_end && !hold_full_q && !accept) state_d = IDLE;
            end
            default: state_d = state_q;
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        byte_out_valid = in_send;
        data_in_ready  = !hold_full_q;
        busy           = in_send || hold_full_q;
    end

    // Shifter: direct load when idle, shift per byte, reload at word end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_q <= '0;
        end else if (!in_send) begin
            if (accept) sh_q <= data_in;
        end else if (xfer) begin
            if (!last) begin
                sh_q <= sh_shifted;
            end else if (hold_full_q) begin
                sh_q <= hold_q;
            end else if (accept) begin
                sh_q <= data_in;
            end
        end
    end

    // Holding register: parks a word only if the shifter is not freeing up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else if (word_end && hold_full_q) begin
            hold_full_q <= 1'b0;
        end else if (in_send && accept && !word_end) begin
            hold_q      <= data_in;
            hold_full_q <= 1'b1;
        end
    end

    // Dropped-word counter, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_result_byte_serializer.sv
// Bench for result_byte_serializer: word-queue model plus
// directed scenarios and randomized traffic.
module tb_result_byte_serializer;

    logic        clk;
    logic        rst;
    logic [31:0] data_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic [7:0]  byte_out;
    logic        byte_out_valid;
    logic        byte_out_ready;
    logic        busy;
    logic [7:0]  drop_cnt;

    result_byte_serializer dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .byte_out       (byte_out),
        .byte_out_valid (byte_out_valid),
        .byte_out_ready (byte_out_ready),
        .busy           (busy),
        .drop_cnt       (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model: words not yet fully sent (head is being emitted), bytes done of head.
    logic [31:0] mq[$];
    int          sent;
    int          mdrop;

    logic [7:0]  log_b[$];
    int          log_c[$];
    logic [7:0]  expq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model_byte();
        logic [31:0] w;
        w = mq[0] >> (8 * (3 - sent));
        return w[7:0];
    endfunction

    // One clock: compare against model mid-cycle, then advance model at the edge.
    task automatic cycle();
        bit acc;
        bit drp;
        bit xf;
        @(negedge clk);
        chk("valid", byte_out_valid, (mq.size() > 0) ? 1 : 0);
        chk("ready", data_in_ready, (mq.size() < 2) ? 1 : 0);
        chk("busy", busy, (mq.size() > 0) ? 1 : 0);
        chk("drop_cnt", drop_cnt, mdrop);
        if (mq.size() > 0) chk("byte", byte_out, model_byte());
        acc = data_in_valid && (mq.size() < 2);
        drp = data_in_valid && !(mq.size() < 2);
        xf  = (mq.size() > 0) && byte_out_ready;
        if (byte_out_valid && byte_out_ready) begin
            log_b.push_back(byte_out);
            log_c.push_back(cyc);
        end
        @(posedge clk);
        if (xf) begin
            sent++;
            if (sent == 4) begin
                void'(mq.pop_front());
                sent = 0;
            end
        end
        if (acc) mq.push_back(data_in);
        if (drp && mdrop < 255) mdrop++;
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        data_in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        data_in_valid = 1'b0;
        byte_out_ready = 1'b0;
        mq.delete();
        sent = 0;
        mdrop = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        log_b.delete();
        log_c.delete();
    endtask

    task automatic check_log(input string nm, input bit contiguous);
        chk({nm, "_len"}, log_b.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            if (i < log_b.size()) chk({nm, "_b"}, log_b[i], expq[i]);
            if (contiguous && i > 0 && i < log_c.size())
                chk({nm, "_gap"}, log_c[i] - log_c[i-1], 1);
        end
        log_b.delete();
        log_c.delete();
    endtask

    task automatic push_word_bytes(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int k = 3; k >= 0; k--) expq.push_back(8'((t >> (8 * k)) & 32'hFF));
    endtask

    int acc_cyc;

    initial begin
        rst = 1'b0;
        data_in = '0;
        data_in_valid = 1'b0;
        byte_out_ready = 1'b0;
        #2;
        chk("rst_valid", byte_out_valid, 0);
        chk("rst_ready", data_in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_byte", byte_out, 0);
        chk("rst_drop", drop_cnt, 0);
        do_reset();

        // Single word, first byte one cycle after accept.
        byte_out_ready = 1'b1;
        data_in = 32'h01020304;
        data_in_valid = 1'b1;
        acc_cyc = cyc;
        cycle();
        idle(6);
        chk("t1_first", (log_c.size() > 0) ? log_c[0] : -1, acc_cyc + 1);
        expq = '{8'h01, 8'h02, 8'h03, 8'h04};
        check_log("t1", 1);
        chk("t1_busy", busy, 0);
        chk("t1_drop", drop_cnt, 0);

        // Two words one cycle apart: second parks, no gap.
        data_in = 32'hAABBCCDD;
        data_in_valid = 1'b1;
        cycle();
        data_in = 32'h11223344;
        cycle();
        data_in_valid = 1'b0;
        chk("t2_ready_low", data_in_ready, 0);
        idle(10);
        expq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
        check_log("t2", 1);

        // Backpressure on the second byte.
        data_in = 32'h01020304;
        data_in_valid = 1'b1;
        cycle();
        data_in_valid = 1'b0;
        cycle();
        byte_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t3_hold_byte", byte_out, 8'h02);
            chk("t3_hold_valid", byte_out_valid, 1);
        end
        byte_out_ready = 1'b1;
        idle(5);
        expq = '{8'h01, 8'h02, 8'h03, 8'h04};
        check_log("t3", 0);

        // Overrun: third word dropped.
        byte_out_ready = 1'b0;
        data_in_valid = 1'b1;
        data_in = 32'h1; cycle();
        data_in = 32'h2; cycle();
        data_in = 32'h3; cycle();
        data_in_valid = 1'b0;
        cycle();
        chk("t4_drop", drop_cnt, 1);
        byte_out_ready = 1'b1;
        idle(10);
        expq = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
        check_log("t4", 1);

        // Saturation of the drop counter.
        do_reset();
        data_in_valid = 1'b1;
        for (int i = 0; i < 302; i++) begin
            data_in = $urandom;
            cycle();
        end
        data_in_valid = 1'b0;
        cycle();
        chk("t5_sat", drop_cnt, 255);
        byte_out_ready = 1'b1;
        idle(10);

        // Asynchronous reset in the middle of a word.
        log_b.delete();
        log_c.delete();
        data_in = 32'hDEADBEEF;
        data_in_valid = 1'b1;
        cycle();
        data_in_valid = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("t6_valid", byte_out_valid, 0);
        chk("t6_ready", data_in_ready, 1);
        chk("t6_drop", drop_cnt, 0);
        chk("t6_busy", busy, 0);
        expq = '{8'hDE, 8'hAD};
        check_log("t6a", 1);
        do_reset();
        byte_out_ready = 1'b1;
        data_in = 32'h0000FF00;
        data_in_valid = 1'b1;
        cycle();
        idle(6);
        expq = '{8'h00, 8'h00, 8'hFF, 8'h00};
        check_log("t6b", 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            data_in = $urandom;
            data_in_valid = ($urandom_range(0, 99) < 40);
            byte_out_ready = ($urandom_range(0, 99) < 70);
            cycle();
        end
        byte_out_ready = 1'b1;
        idle(12);
        chk("end_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/result_byte_serializer.md
# result_byte_serializer

Downstream stage of the p**4 power unit: takes each 32-bit result word offered on a valid/ready input and emits it as four 8-bit bytes on a valid/ready byte stream for the byte-wide output link. A one-word holding register lets the next result land while the current word is still being shifted out. Results offered while the holding register is full are counted as dropped, because the power unit has no backpressure input.

## Interface
- DATA_W, 32, input word width; must be a multiple of BYTE_W
- BYTE_W, 8, output byte width
- MSB_FIRST, 1, 1: most significant byte first; 0: least significant byte first
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- data_in  input  DATA_W  result word
- data_in_valid  input  1  data_in holds a word this cycle
- data_in_ready  output  1  block can accept a word this cycle
- byte_out  output  BYTE_W  current output byte
- byte_out_valid  output  1  byte_out is valid
- byte_out_ready  input  1  sink accepts byte_out this cycle
- busy  output  1  shifter or holding register occupied
- drop_cnt  output  8  saturating count of dropped words

## Operation
- Internal state:
  - shift register `sh` (DATA_W)
  - byte index `idx` (0..NBYTES-1, where NBYTES = DATA_W/BYTE_W)
  - holding register `hold` plus flag `hold_full`
  - FSM with states IDLE and SEND
- Input accept: occurs when data_in_valid && data_in_ready.
- data_in_ready = !hold_full. It is a function of registered state only, with no combinational path from data_in_valid.
- Drop: data_in_valid && !data_in_ready. The word is discarded and drop_cnt increments, saturating at 255.
- Byte transfer: occurs when byte_out_valid && byte_out_ready.
- byte_out = top BYTE_W bits of `sh` when MSB_FIRST=1, bottom bits when MSB_FIRST=0. After each transfer `sh` shifts by BYTE_W toward the emitting end.
- IDLE:
  - byte_out_valid = 0.
  - Accept loads `sh` directly, sets idx=0, goes to SEND. `hold` is not used.
- SEND:
  - byte_out_valid = 1. byte_out and byte_out_valid stay stable until the byte transfers.
  - Accept while SEND stores the word into `hold` and sets hold_full.
  - Transfer with idx < NBYTES-1: shift `sh`, idx++.
  - Transfer with idx = NBYTES-1 (last byte), in priority order:
    - If hold_full: `sh` <= hold, hold_full <= 0, idx <= 0, stay in SEND. Any same-cycle input is dropped, since ready was low.
    - Else if an accept occurs the same cycle: `sh` <= data_in, idx <= 0, stay in SEND. `hold` stays empty.
    - Else: go to IDLE.
- busy = (state == SEND) || hold_full.
- Reset, asynchronous: state=IDLE, idx=0, hold_full=0, sh=0, hold=0, drop_cnt=0.
- Reset values of the outputs: byte_out=0, byte_out_valid=0, data_in_ready=1, busy=0, drop_cnt=0.
- Reset mid-word: partial words are discarded and no further bytes are emitted.

## Timing
- Latency: accept in cycle N (IDLE) -> first byte valid in cycle N+1.
- Throughput: one word per NBYTES cycles when byte_out_ready is held at 1.
- Back-to-back words (via `hold` or the direct last-byte reload) produce no bubble between the last byte of one word and the first byte of the next.
- drop_cnt updates on the cycle after the drop.
- All outputs are registered or decoded from registered state only, except byte_out, which is a slice of `sh`.

## Structure
- Package `serializer_pkg`:
  - DATA_W and BYTE_W defaults
  - NBYTES localparam
  - IDX_W = $clog2(NBYTES)
  - state enum {IDLE, SEND}
- One sub-module: `byte_index_counter`, an IDX_W-bit counter with synchronous clear and enable, async active-low reset, and a terminal-count output (idx == NBYTES-1).
- The FSM, holding register, shifter and drop counter live in the top of this block.

## Test plan
- Single word, MSB_FIRST=1, byte_out_ready=1, data_in=0x01020304 -> bytes 0x01,0x02,0x03,0x04 on four consecutive cycles starting one cycle after accept; then IDLE, busy=0, drop_cnt=0.
- Two words 0xAABBCCDD and 0x11223344 offered one cycle apart, ready=1 -> second word goes to `hold`, data_in_ready low; eight bytes AA,BB,CC,DD,11,22,33,44 with no gap.
- Backpressure: byte_out_ready low for 3 cycles while byte 0x02 of 0x01020304 is presented -> byte_out holds 0x02 and byte_out_valid stays 1; sequence resumes intact.
- Overrun: three words 0x1, 0x2, 0x3 on consecutive cycles with byte_out_ready=0 -> words 1 and 2 retained, word 3 dropped, drop_cnt=1; later output is bytes of 0x1 then 0x2 only.
- Drop counter saturation: 300 words offered while hold_full -> drop_cnt stops at 255.
- Reset mid-word: rst=0 after 2 bytes of 0xDEADBEEF -> byte_out_valid=0, data_in_ready=1, drop_cnt=0 immediately (asynchronous); after release, a new word 0x0000FF00 emits 00,00,FF,00.
